// File: rtl/memory_arbiter.sv
// Arbitrates one unified RAM port between instruction fetch and data load/store; data wins.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module memory_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

    state_t state, state_nxt;
    logic   own_en;
    logic   in_access;
    logic   ram_done;
    logic   tmo;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Counter sits at zero in IDLE so the first access cycle sees 0.
    always_ff @(posedge CLK) begin
        if (RST || state == IDLE)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tmo = in_access && (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        own_en = 1'b0;
        case (state)
            IFETCH:  own_en = iREN;
            DREAD:   own_en = dREN;
            DWRITE:  own_en = dWEN;
            default: own_en = 1'b0;
        endcase
    end

    assign in_access = (state != IDLE);
    assign ram_done  = in_access && (ramstate == RS_ACCESS || ramstate == RS_ERROR || tmo);

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (dWEN)
                state_nxt = DWRITE;
            else if (dREN)
                state_nxt = DREAD;
            else if (iREN)
                state_nxt = IFETCH;
        end else if (!own_en || ram_done) begin
            state_nxt = IDLE;
        end
    end

    // A dropped enable is an abort, which never reports an error.
    assign err = in_access && own_en && !RST &&
                 (ramstate == RS_ERROR || (tmo && ramstate != RS_ACCESS));

    assign iwait = iREN && !(state == IFETCH && ram_done);
    assign dwait = (dREN || dWEN) && !((state == DREAD || state == DWRITE) && ram_done);

    // RAM-facing controls decode from the registered state only.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        case (state)
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = ramload;
            end
            DREAD: begin
                ramREN  = 1'b1;
                ramaddr = daddr;
                dload   = ramload;
            end
            DWRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter; define MEM_TIMEOUT_EN to exercise the watchdog (TIMEOUT=4).
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int passed = 0;
    int total  = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    memory_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
        tick(); tick();
        total++; if (ramREN !== 1'b0) $display("FAIL rst_ramREN got %0b want 0", ramREN); else passed++;
        total++; if (ramWEN !== 1'b0) $display("FAIL rst_ramWEN got %0b want 0", ramWEN); else passed++;
        total++; if (ramaddr !== 32'h0) $display("FAIL rst_ramaddr got %h want 0", ramaddr); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rst_err got %0b want 0", err); else passed++;
        total++; if (iwait !== 1'b1) $display("FAIL rst_iwait got %0b want 1", iwait); else passed++;
        total++; if (iload !== 32'h0) $display("FAIL rst_iload got %h want 0", iload); else passed++;
        iREN = 1'b0; RST = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; #1;
        total++; if (ramREN !== 1'b0) $display("FAIL fetch_idle_ramREN got %0b want 0", ramREN); else passed++;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (ramREN !== 1'b1 || ramaddr !== 32'h40)
                $display("FAIL fetch_busy%0d got ren=%0b addr=%h want ren=1 addr=00000040", k, ramREN, ramaddr);
            else passed++;
            total++; if (iwait !== 1'b1) $display("FAIL fetch_busy_iwait%0d got %0b want 1", k, iwait); else passed++;
        end
        tick();
        ramstate = ACCESS; ramload = 32'h3C010001; #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h40)
            $display("FAIL fetch_access got ren=%0b addr=%h want ren=1 addr=00000040", ramREN, ramaddr);
        else passed++;
        total++; if (iwait !== 1'b0) $display("FAIL fetch_iwait got %0b want 0", iwait); else passed++;
        total++; if (iload !== 32'h3C010001) $display("FAIL fetch_iload got %h want 3c010001", iload); else passed++;
        total++; if (err !== 1'b0) $display("FAIL fetch_err got %0b want 0", err); else passed++;
        tick();
        iREN = 1'b0; ramstate = FREE; #1;
        total++; if (ramREN !== 1'b0 || iload !== 32'h0)
            $display("FAIL fetch_after got ren=%0b iload=%h want ren=0 iload=0", ramREN, iload);
        else passed++;
    endtask

    task automatic test_priority();
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; dREN = 1'b1;
        daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = BUSY;
        tick();
        total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0)
            $display("FAIL prio_write got wen=%0b ren=%0b want wen=1 ren=0", ramWEN, ramREN);
        else passed++;
        total++; if (ramaddr !== 32'h80 || ramstore !== 32'hDEADBEEF)
            $display("FAIL prio_wdata got addr=%h data=%h want 00000080 deadbeef", ramaddr, ramstore);
        else passed++;
        total++; if (iwait !== 1'b1 || dwait !== 1'b1)
            $display("FAIL prio_waits got i=%0b d=%0b want 1 1", iwait, dwait);
        else passed++;
        total++; if (dload !== 32'h0) $display("FAIL prio_dload got %h want 0", dload); else passed++;
        ramstate = ACCESS; #1;
        total++; if (dwait !== 1'b0 || iwait !== 1'b1)
            $display("FAIL prio_done got i=%0b d=%0b want 1 0", iwait, dwait);
        else passed++;
        tick();
        dWEN = 1'b0; dREN = 1'b0; ramstate = BUSY; #1;
        total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || iwait !== 1'b1)
            $display("FAIL prio_gap got wen=%0b ren=%0b iwait=%0b want 0 0 1", ramWEN, ramREN, iwait);
        else passed++;
        tick();
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h44)
            $display("FAIL prio_ifetch got ren=%0b addr=%h want 1 00000044", ramREN, ramaddr);
        else passed++;
        ramstate = ACCESS; ramload = 32'h12345678; #1;
        total++; if (iwait !== 1'b0 || iload !== 32'h12345678)
            $display("FAIL prio_ifetch_done got iwait=%0b iload=%h want 0 12345678", iwait, iload);
        else passed++;
        tick();
        iREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    task automatic test_error_abort();
        dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
        tick();
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || err !== 1'b0)
            $display("FAIL err_dread got ren=%0b addr=%h err=%0b want 1 00000100 0", ramREN, ramaddr, err);
        else passed++;
        ramstate = ERROR; ramload = 32'h00000BAD; #1;
        total++; if (err !== 1'b1 || dwait !== 1'b0 || dload !== 32'h00000BAD)
            $display("FAIL err_pulse got err=%0b dwait=%0b dload=%h want 1 0 00000bad", err, dwait, dload);
        else passed++;
        tick();
        ramstate = BUSY; #1;
        total++; if (ramREN !== 1'b0 || err !== 1'b0)
            $display("FAIL err_idle got ren=%0b err=%0b want 0 0", ramREN, err);
        else passed++;
        tick();
        tick();
        total++; if (ramREN !== 1'b1) $display("FAIL abort_busy got ren=%0b want 1", ramREN); else passed++;
        dREN = 1'b0; #1;
        total++; if (err !== 1'b0 || dwait !== 1'b0)
            $display("FAIL abort_drop got err=%0b dwait=%0b want 0 0", err, dwait);
        else passed++;
        tick();
        total++; if (ramREN !== 1'b0 || err !== 1'b0)
            $display("FAIL abort_idle got ren=%0b err=%0b want 0 0", ramREN, err);
        else passed++;
        ramstate = FREE;
        tick();
    endtask

    task automatic test_reset_mid();
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1; ramstate = BUSY;
        tick();
        total++; if (ramWEN !== 1'b1) $display("FAIL rmid_write got wen=%0b want 1", ramWEN); else passed++;
        RST = 1'b1; #1;
        total++; if (err !== 1'b0) $display("FAIL rmid_err got %0b want 0", err); else passed++;
        tick();
        total++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0 || err !== 1'b0)
            $display("FAIL rmid_after got wen=%0b addr=%h err=%0b want 0 0 0", ramWEN, ramaddr, err);
        else passed++;
        RST = 1'b0; dWEN = 1'b0;
        tick();
        total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0)
            $display("FAIL rmid_idle got wen=%0b ren=%0b want 0 0", ramWEN, ramREN);
        else passed++;
        ramstate = FREE;
    endtask

    task automatic test_timeout();
        iREN = 1'b1; iaddr = 32'h60; ramstate = BUSY;
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            total++; if (iwait !== 1'b1 || err !== 1'b0 || ramREN !== 1'b1)
                $display("FAIL tmo_wait%0d got iwait=%0b err=%0b ren=%0b want 1 0 1", k, iwait, err, ramREN);
            else passed++;
            tick();
        end
        total++; if (err !== 1'b1 || iwait !== 1'b0 || ramREN !== 1'b1)
            $display("FAIL tmo_fire got err=%0b iwait=%0b ren=%0b want 1 0 1", err, iwait, ramREN);
        else passed++;
        iREN = 1'b0;
        tick();
        total++; if (ramREN !== 1'b0 || err !== 1'b0)
            $display("FAIL tmo_idle got ren=%0b err=%0b want 0 0", ramREN, err);
        else passed++;
`else
        for (int k = 0; k < 100; k++) tick();
        total++; if (iwait !== 1'b1 || err !== 1'b0 || ramREN !== 1'b1 || ramaddr !== 32'h60)
            $display("FAIL hold_100 got iwait=%0b err=%0b ren=%0b addr=%h want 1 0 1 00000060",
                     iwait, err, ramREN, ramaddr);
        else passed++;
        iREN = 1'b0;
        tick();
        total++; if (ramREN !== 1'b0) $display("FAIL hold_abort got ren=%0b want 0", ramREN); else passed++;
`endif
        ramstate = FREE;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_error_abort();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
